// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID/EX/MEM hazard inputs and pipeline control outputs
interface pipeline_hazard_ctrl_if;
  logic [5:0]  opcode_id;
  logic [4:0]  reg1_id;
  logic [4:0]  reg2_id;
  logic [4:0]  ex_dst;
  logic        ex_wb;
  logic        ex_is_load;
  logic [4:0]  mem_dst;
  logic        mem_wb;
  logic        branch_taken_ex;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        stall_timeout;
  modport master (
    output opcode_id, reg1_id, reg2_id, ex_dst, ex_wb, ex_is_load, mem_dst, mem_wb, branch_taken_ex,
    input  pc_en, ifid_en, ifid_flush, idex_flush, state_o, stall_cnt, flush_cnt, stall_timeout
  );
  modport slave (
    input  opcode_id, reg1_id, reg2_id, ex_dst, ex_wb, ex_is_load, mem_dst, mem_wb, branch_taken_ex,
    output pc_en, ifid_en, ifid_flush, idex_flush, state_o, stall_cnt, flush_cnt, stall_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: MIPS 5-stage hazard detection, stall/flush sequencing and statistics
module pipeline_hazard_ctrl #(
  parameter bit FORWARDING   = 1'b1,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_MAX    = 15
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_LIMIT  = 8'(STALL_MAX);
  state_t      r_state, w_next;
  logic [2:0]  r_fcnt, w_fcnt_next;
  logic [7:0]  r_consec, w_consec_next;
  logic [15:0] r_stall_cnt, r_flush_cnt;
  logic        r_timeout;
  logic        w_rs_used, w_rt_used, w_haz, w_stall;
  logic        w_pc_en, w_ifid_en, w_ifid_flush, w_idex_flush;
  function automatic logic src_hazard(input logic [4:0] s, input logic [4:0] ed, input logic ew,
                                      input logic ld, input logic [4:0] md, input logic mw);
    return (s != 5'd0) & (FORWARDING ? (ew & ld & (ed == s)) : ((ew & (ed == s)) | (mw & (md == s))));
  endfunction
  assign w_rs_used = !(bus.opcode_id == 6'b000010 || bus.opcode_id == 6'b000011);
  assign w_rt_used = bus.opcode_id == 6'b000000 || bus.opcode_id == 6'b101011 ||
                     bus.opcode_id == 6'b000100 || bus.opcode_id == 6'b000101;
  assign w_haz = (w_rs_used & src_hazard(bus.reg1_id, bus.ex_dst, bus.ex_wb, bus.ex_is_load, bus.mem_dst, bus.mem_wb)) |
                 (w_rt_used & src_hazard(bus.reg2_id, bus.ex_dst, bus.ex_wb, bus.ex_is_load, bus.mem_dst, bus.mem_wb));
  // Next state and Mealy controls: branch beats everything, FLUSH masks hazards, else stall on hazard
  always_comb begin
    w_next       = RUN;
    w_fcnt_next  = r_fcnt;
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_stall      = 1'b0;
    if (bus.branch_taken_ex) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_next       = FLUSH;
      w_fcnt_next  = FLUSH_RELOAD;
    end else if (r_state == FLUSH) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_next       = (r_fcnt == 3'd0) ? RUN : FLUSH;
      w_fcnt_next  = (r_fcnt == 3'd0) ? 3'd0 : r_fcnt - 3'd1;
    end else if (w_haz) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
      w_next       = STALL;
      w_stall      = 1'b1;
    end
  end
  assign w_consec_next = w_stall ? ((r_consec == 8'hFF) ? r_consec : r_consec + 8'd1) : 8'd0;
  // State, flush countdown, saturating statistics and sticky watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_fcnt      <= 3'd0;
      r_consec    <= 8'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_fcnt      <= w_fcnt_next;
      r_consec    <= w_consec_next;
      r_stall_cnt <= (w_stall && r_stall_cnt != 16'hFFFF) ? r_stall_cnt + 16'd1 : r_stall_cnt;
      r_flush_cnt <= (bus.branch_taken_ex && r_flush_cnt != 16'hFFFF) ? r_flush_cnt + 16'd1 : r_flush_cnt;
      r_timeout   <= r_timeout | (w_stall & (w_consec_next >= STALL_LIMIT));
    end
  end
  assign bus.pc_en         = ~rst & w_pc_en;
  assign bus.ifid_en       = ~rst & w_ifid_en;
  assign bus.ifid_flush    = rst | w_ifid_flush;
  assign bus.idex_flush    = rst | w_idex_flush;
  assign bus.state_o       = r_state;
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.flush_cnt     = r_flush_cnt;
  assign bus.stall_timeout = r_timeout;
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard detection and stall/flush sequencer for the 5-stage MIPS pipeline.
- Watches the decoded ID-stage fields from the IF/ID register, plus the destination and writeback info of EX and MEM.
- Drives the PC enable, the IF/ID hold/flush, and the ID/EX bubble.
- Holds a small FSM for multi-cycle branch flush, plus stall/flush statistics counters and a stall watchdog.

Parameters:
- FORWARDING, 1: 1 = only load-use stalls (forwarding unit present); 0 = any EX/MEM RAW match stalls.
- FLUSH_CYCLES, 1: number of cycles the flush is held after a taken branch (1..7).
- STALL_MAX, 15: consecutive stall cycles before stall_timeout sets (1..255).

Ports:
- clk  in  1  pipeline clock, posedge active
- rst  in  1  synchronous reset, active-high
- opcode_id  in  6  ID-stage opcode
- reg1_id  in  5  ID-stage rs
- reg2_id  in  5  ID-stage rt
- ex_dst  in  5  EX-stage destination register
- ex_wb  in  1  EX-stage instruction writes the register file
- ex_is_load  in  1  EX-stage instruction is LW
- mem_dst  in  5  MEM-stage destination register
- mem_wb  in  1  MEM-stage instruction writes the register file
- branch_taken_ex  in  1  taken branch/jump resolved in EX
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP (ir=0)
- idex_flush  out  1  ID/EX clear to bubble
- state_o  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH
- stall_cnt  out  16  total stall cycles, saturating
- flush_cnt  out  16  total taken-branch flush events, saturating
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Source usage, decoded from opcode_id:
  - rs is used by every opcode except J (000010) and JAL (000011).
  - rt is used by R-type (000000), SW (101011), BEQ (000100) and BNE (000101).
  - Register 0 never causes a hazard.
- Hazard condition (combinational), for a used source s:
  - FORWARDING=1: hazard = ex_wb & ex_is_load & (ex_dst==s).
  - FORWARDING=0: hazard = (ex_wb & ex_dst==s) | (mem_wb & mem_dst==s).
  - The register file writes in the first half-cycle, so WB is never checked.
- Outputs are Mealy: a function of current state plus the current cycle's inputs. There is no added latency; the stall applies in the same cycle the hazard is visible.
- RUN, no hazard, no branch: pc_en=1, ifid_en=1, both flushes 0.
- Taken branch (branch_taken_ex=1) in any state has priority over a hazard:
  - This cycle: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
  - Next state: FLUSH with flush counter = FLUSH_CYCLES-1.
  - flush_cnt increments.
- Hazard with no branch:
  - This cycle: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1 (bubble).
  - Next state: STALL; stall_cnt increments.
- STALL state:
  - Same outputs as above while the hazard persists.
  - When the hazard clears: RUN outputs this cycle, next state RUN.
  - Consecutive-stall counter (8-bit) increments on every stall cycle and clears on any non-stall cycle.
  - When it reaches STALL_MAX, stall_timeout sets and stays set until rst. The stall itself continues.
- FLUSH state:
  - ifid_flush=1, idex_flush=1, pc_en=1, ifid_en=1.
  - Hazards are ignored, because the instructions are squashed.
  - Counter decrements each cycle; at 0, next state RUN.
  - FLUSH_CYCLES=1 means the state returns to RUN after a single FLUSH cycle.
  - A new branch_taken_ex in FLUSH reloads the counter and increments flush_cnt.
- Counters saturate at 16'hFFFF and never wrap.
- Reset (rst=1 sampled at posedge):
  - state=RUN; stall_cnt=0, flush_cnt=0; consecutive counter=0; stall_timeout=0.
  - While rst is high, outputs are forced pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, so the pipeline is cleared to NOPs.
  - Reset mid-STALL or mid-FLUSH abandons the operation immediately. The first cycle after rst deasserts is RUN.
- Simultaneous branch and hazard: branch wins, and the stall counters do not change.
- No stage-valid inputs exist: flushed stages carry NOP (ir=0), which decodes as R-type sll $0, and rd=0 never writes.

Test Plan:
- rst high 2 cycles -> pc_en=0, ifid_flush=1, idex_flush=1, all counters 0; first cycle after rst falls -> state_o=0, pc_en=1.
- FORWARDING=1: ex_is_load=1, ex_wb=1, ex_dst=5, reg1_id=5, opcode_id=000000 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 for that cycle; next cycle with the hazard gone -> RUN, stall_cnt=1.
- FORWARDING=0: mem_wb=1, mem_dst=8, reg2_id=8, opcode_id=101011 (SW) -> stall. Same case with opcode_id=001000 (ADDI, rt unused) -> no stall. reg1_id=0 with ex_dst=0 -> no stall.
- FLUSH_CYCLES=3: branch_taken_ex pulse 1 cycle -> ifid_flush=idex_flush=1 for 4 consecutive cycles (trigger + 3 FLUSH), then RUN; flush_cnt=1. A load-use hazard injected during FLUSH -> no stall.
- Branch and hazard in the same cycle -> flush outputs, pc_en=1, stall_cnt unchanged, state_o=2 next cycle.
- STALL_MAX=4: hazard held 6 cycles -> stall_timeout rises after the 4th stall cycle and stays 1 after the hazard clears. stall_cnt=6. rst clears both. Saturation check: preload 65535 stall cycles -> stall_cnt stays 16'hFFFF.
